// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 multichannel fader: run-time modes,
// brightness scale width and milestone store sizing.
package ws2812_pkg;

    typedef enum logic [1:0] {
        MODE_SCROLL = 2'd0,
        MODE_FREEZE = 2'd1,
        MODE_BLANK  = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    localparam int BRIGHT_W = 8;
    localparam logic [BRIGHT_W-1:0] BRIGHT_UNITY = 8'd255;

    // One milestone per INTERPOLATIONS LEDs, plus one so the last segment has an end point.
    function automatic int milestone_count(input int leds, input int interps);
        return (leds + interps - 1) / interps + 1;
    endfunction

endpackage

// File: rtl/ws2812_color_interp.sv
// Combinational linear interpolation between two milestone bytes followed by
// global brightness scaling (brightness 255 is unity).
module ws2812_color_interp
    import ws2812_pkg::*;
#(
    parameter int COLOR_WIDTH    = 8,
    parameter int INTERPOLATIONS = 16
) (
    input  logic [COLOR_WIDTH-1:0]             a,
    input  logic [COLOR_WIDTH-1:0]             b,
    input  logic [$clog2(INTERPOLATIONS)-1:0]  ip,
    input  logic [BRIGHT_W-1:0]                brightness,
    output logic [COLOR_WIDTH-1:0]             color
);

    localparam int IP_W   = $clog2(INTERPOLATIONS);
    localparam int SUM_W  = COLOR_WIDTH + IP_W + 1;
    localparam int PROD_W = COLOR_WIDTH + BRIGHT_W + 1;

    logic [SUM_W-1:0]       wa, wb, sum;
    logic [COLOR_WIDTH-1:0] lerp;
    logic [PROD_W-1:0]      prod;

    always_comb begin
        wb   = SUM_W'(ip);
        wa   = SUM_W'(INTERPOLATIONS) - wb;
        sum  = SUM_W'(a) * wa + SUM_W'(b) * wb;
        lerp = COLOR_WIDTH'(sum >> IP_W);
        // brightness+1 keeps 255 an exact pass-through after the >> 8
        prod  = PROD_W'(lerp) * PROD_W'({1'b0, brightness} + 9'd1);
        color = COLOR_WIDTH'(prod >> BRIGHT_W);
    end

endmodule

// File: rtl/ws2812_multichannel_fader.sv
// Scrolling gradient source for a WS2812 serialiser: one colour byte per
// accepted data_request, milestone shift store, holdoff and frame-boundary mode latch.
module ws2812_multichannel_fader
    import ws2812_pkg::*;
#(
    parameter int LEDS           = 128,
    parameter int CHANNELS       = 3,
    parameter int COLOR_WIDTH    = 8,
    parameter int RAND_BITS      = 5,
    parameter int INTERPOLATIONS = 16,
    parameter int HOLDOFF_TIME   = 700000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNELS*RAND_BITS-1:0] random,
    input  logic [1:0]                    mode,
    input  logic [BRIGHT_W-1:0]           brightness,
    input  logic                          data_request,
    output logic                          trigger,
    output logic [COLOR_WIDTH-1:0]        color_now,
    output logic                          frame_done
);

    localparam int M     = milestone_count(LEDS, INTERPOLATIONS);
    localparam int LED_W = $clog2(LEDS);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int MS_W  = $clog2(M);
    localparam int IP_W  = $clog2(INTERPOLATIONS);
    localparam int HO_W  = (HOLDOFF_TIME > 0) ? $clog2(HOLDOFF_TIME + 1) : 1;
    localparam int PAD_W = COLOR_WIDTH - RAND_BITS;

    logic [M-1:0][CHANNELS-1:0][COLOR_WIDTH-1:0] mil;
    logic [CHANNELS-1:0][COLOR_WIDTH-1:0]        fresh;

    logic [LED_W-1:0] led;
    logic [CH_W-1:0]  ch;
    logic [MS_W-1:0]  ms, ms_b;
    logic [IP_W-1:0]  ip, start_ip;
    logic [HO_W-1:0]  holdoff;
    mode_e            mode_q;

    logic last_ch, last_led, last_ip;
    logic [COLOR_WIDTH-1:0] col_a, col_b, scaled;

    assign trigger  = (holdoff == '0);
    assign last_ch  = (ch == CH_W'(CHANNELS - 1));
    assign last_led = (led == LED_W'(LEDS - 1));
    assign last_ip  = &ip;

    // New milestone: random bits left-aligned in the colour byte.
    always_comb begin
        fresh = '0;
        for (int c = 0; c < CHANNELS; c++)
            fresh[c] = COLOR_WIDTH'(random[c*RAND_BITS +: RAND_BITS]) << PAD_W;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led        <= '0;
            ch         <= '0;
            ms         <= '0;
            ip         <= '0;
            start_ip   <= '0;
            holdoff    <= '0;
            mode_q     <= MODE_SCROLL;
            frame_done <= 1'b0;
            mil        <= '0;
        end else begin
            frame_done <= 1'b0;
            if (!trigger) begin
                holdoff <= holdoff - 1'b1;
            end else if (data_request) begin
                if (!last_ch) begin
                    ch <= ch + 1'b1;
                end else begin
                    ch <= '0;
                    if (!last_led) begin
                        led <= led + 1'b1;
                        if (!last_ip) begin
                            ip <= ip + 1'b1;
                        end else begin
                            ip <= '0;
                            ms <= ms + 1'b1;
                        end
                    end else begin
                        holdoff    <= HO_W'(HOLDOFF_TIME);
                        led        <= '0;
                        ms         <= '0;
                        frame_done <= 1'b1;
                        mode_q     <= mode_e'(mode);
                        // The action below is driven by the mode that governed the frame just sent.
                        if (mode_q == MODE_SCROLL) begin
                            if (start_ip != '0) begin
                                start_ip <= start_ip - 1'b1;
                                ip       <= start_ip - 1'b1;
                            end else begin
                                start_ip <= IP_W'(INTERPOLATIONS - 1);
                                ip       <= IP_W'(INTERPOLATIONS - 1);
                                mil      <= {mil[M-2:0], fresh};
                            end
                        end else begin
                            ip <= start_ip;
                        end
                    end
                end
            end
        end
    end

    // At ms == M-1 the upper neighbour would fall off the store; reuse a.
    assign ms_b  = (ms == MS_W'(M - 1)) ? ms : ms + 1'b1;
    assign col_a = mil[ms][ch];
    assign col_b = mil[ms_b][ch];

    ws2812_color_interp #(
        .COLOR_WIDTH    (COLOR_WIDTH),
        .INTERPOLATIONS (INTERPOLATIONS)
    ) u_interp (
        .a          (col_a),
        .b          (col_b),
        .ip         (ip),
        .brightness (brightness),
        .color      (scaled)
    );

    assign color_now = (mode_q == MODE_BLANK) ? '0 : scaled;

endmodule

// File: tb/tb_ws2812_multichannel_fader.sv
// Directed bench for the WS2812 multichannel fader on a 4-LED RGB strip with
// two interpolation steps and a 5-cycle holdoff.
module tb_ws2812_multichannel_fader;

    logic        clk;
    logic        rst_n;
    logic [14:0] random;
    logic [1:0]  mode;
    logic [7:0]  brightness;
    logic        data_request;
    logic        trigger;
    logic [7:0]  color_now;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0;

    logic [7:0] ex [12];
    logic [7:0] dx [3];

    ws2812_multichannel_fader #(
        .LEDS           (4),
        .CHANNELS       (3),
        .COLOR_WIDTH    (8),
        .RAND_BITS      (5),
        .INTERPOLATIONS (2),
        .HOLDOFF_TIME   (5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .random       (random),
        .mode         (mode),
        .brightness   (brightness),
        .data_request (data_request),
        .trigger      (trigger),
        .color_now    (color_now),
        .frame_done   (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n && trigger === 1'b1 && data_request === 1'b1) acc_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        chk({tag, " trigger"}, trigger, 1);
        chk({tag, " color"}, color_now, 0);
        chk({tag, " frame_done"}, frame_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Sends nbytes of a frame, checking each byte against ex[]; a full frame
    // also checks the frame_done pulse and the holdoff length.
    task automatic run_frame(input string tag, input int nbytes, input bit hold, input bit dim);
        int t, low, fd_extra, a0;
        t = 0;
        while (trigger !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        chk({tag, " ready"}, trigger, 1);
        a0 = acc_cnt;
        for (int i = 0; i < nbytes; i++) begin
            if (dim && i < 3) begin
                brightness = 8'd127;
                #1;
                chk($sformatf("%s dim%0d", tag, i), color_now, dx[i]);
                brightness = 8'd255;
                #1;
            end
            chk($sformatf("%s b%0d", tag, i), color_now, ex[i]);
            data_request = 1'b1;
            step();
            if (!hold) begin
                data_request = 1'b0;
                if (i < nbytes - 1) begin
                    step();
                    chk($sformatf("%s idle%0d", tag, i), color_now, ex[i+1]);
                end
            end
        end
        if (nbytes == 12) begin
            chk({tag, " fd"}, frame_done, 1);
            chk({tag, " trig_low"}, trigger, 0);
            low = 0;
            fd_extra = 0;
            while (trigger !== 1'b1 && low < 50) begin
                low++;
                step();
                if (frame_done !== 1'b0) fd_extra++;
            end
            chk({tag, " holdoff"}, low, 5);
            chk({tag, " fd_once"}, fd_extra, 0);
            chk({tag, " accepts"}, acc_cnt - a0, 12);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        data_request = 1'b0;
        mode = 2'd0;
        brightness = 8'd255;
        random = {5'd31, 5'd16, 5'd1};
        #2;
        do_reset("reset");

        ex = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_frame("f1", 12, 1'b0, 1'b0);

        mode = 2'd1;
        ex = '{4, 64, 124, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        dx = '{2, 32, 62};
        run_frame("f2", 12, 1'b0, 1'b1);

        ex = '{8, 128, 248, 4, 64, 124, 0, 0, 0, 0, 0, 0};
        run_frame("f3_hold", 12, 1'b1, 1'b0);

        mode = 2'd2;
        run_frame("f4_freeze", 12, 1'b0, 1'b0);

        mode = 2'd0;
        ex = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_frame("f5_blank", 12, 1'b0, 1'b0);

        random = {5'd2, 5'd4, 5'd8};
        ex = '{8, 128, 248, 4, 64, 124, 0, 0, 0, 0, 0, 0};
        run_frame("f6_resume", 12, 1'b0, 1'b0);

        ex = '{36, 80, 132, 8, 128, 248, 4, 64, 124, 0, 0, 0};
        run_frame("f7_scroll", 12, 1'b0, 1'b0);

        ex = '{64, 32, 16, 36, 80, 132, 0, 0, 0, 0, 0, 0};
        run_frame("f8_part", 5, 1'b0, 1'b0);
        chk("f8 b5", color_now, 132);
        do_reset("midreset");

        random = {5'd31, 5'd16, 5'd1};
        ex = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_frame("r_f1", 12, 1'b0, 1'b0);
        ex = '{4, 64, 124, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        run_frame("r_f2", 12, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
